// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port data memory.
// Optional define MEMARB_LOCK_EN adds lock0/lock1 so a requester can hold the memory for read-modify-write.
module mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
`ifdef MEMARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [AW-1:0] memaddr,
    output logic [DW-1:0] memdata_in,
    output logic          memwr_en,
    input  logic [DW-1:0] memdata_o
);

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t        r_state;
    logic          r_last;
    logic          r_sel;
    logic          r_we;
    logic [1:0]    r_cnt;

    logic          w_req0;
    logic          w_req1;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

`ifdef MEMARB_LOCK_EN
    logic          r_locked;
    logic          w_lock_sel;

    assign w_lock_sel = r_sel ? lock1 : lock0;
`endif

    // Request masking under lock, round-robin winner and winner's command mux
    always_comb begin
        w_req0 = req0;
        w_req1 = req1;
`ifdef MEMARB_LOCK_EN
        // The lock owner is always r_last, since it was the most recent grant
        if (r_locked && !r_last && req0) begin
            w_req1 = 1'b0;
        end else if (r_locked && r_last && req1) begin
            w_req0 = 1'b0;
        end else begin
            w_req0 = req0;
            w_req1 = req1;
        end
`endif
        if (w_req0 && w_req1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = w_req1;
        end
        if (w_sel) begin
            w_we    = we1;
            w_addr  = addr1;
            w_wdata = wdata1;
        end else begin
            w_we    = we0;
            w_addr  = addr0;
            w_wdata = wdata0;
        end
    end

    // Sequencer FSM; every output is registered and memaddr/memdata_in hold between accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= 2'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= {DW{1'b0}};
            rdata1     <= {DW{1'b0}};
            memaddr    <= {AW{1'b0}};
            memdata_in <= {DW{1'b0}};
            memwr_en   <= 1'b0;
`ifdef MEMARB_LOCK_EN
            r_locked   <= 1'b0;
`endif
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            memwr_en <= 1'b0;
            case (r_state)
                ST_ARB: begin
`ifdef MEMARB_LOCK_EN
                    r_locked <= 1'b0;
`endif
                    if (w_req0 || w_req1) begin
                        r_sel   <= w_sel;
                        r_we    <= w_we;
                        r_last  <= w_sel;
                        gnt0    <= ~w_sel;
                        gnt1    <= w_sel;
                        memaddr <= w_addr;
                        if (w_we) begin
                            memdata_in <= w_wdata;
                            memwr_en   <= 1'b1;
                        end else begin
                            memdata_in <= memdata_in;
                        end
                        r_state <= ST_ACCESS;
                    end else begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ACCESS: begin
`ifdef MEMARB_LOCK_EN
                    r_locked <= w_lock_sel;
`endif
                    if (r_we) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_cnt   <= LAT_LOAD;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_sel) begin
                            rvalid1 <= 1'b1;
                            rdata1  <= memdata_o;
                        end else begin
                            rvalid0 <= 1'b1;
                            rdata0  <= memdata_o;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_ARB;
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT 1 and 3) share one stimulus stream and are
// compared every cycle against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
`ifdef MEMARB_LOCK_EN
    logic       lock0, lock1;
`endif

    logic       a_gnt0, a_gnt1, a_rv0, a_rv1, a_we;
    logic [7:0] a_rd0, a_rd1, a_addr, a_din, a_dout;
    logic       b_gnt0, b_gnt1, b_rv0, b_rv1, b_we;
    logic [7:0] b_rd0, b_rd1, b_addr, b_din, b_dout;

    mem_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
`ifdef MEMARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .memaddr(a_addr), .memdata_in(a_din), .memwr_en(a_we), .memdata_o(a_dout)
    );

    mem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
`ifdef MEMARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .memaddr(b_addr), .memdata_in(b_din), .memwr_en(b_we), .memdata_o(b_dout)
    );

    // Memories: read data appears RD_LAT cycles after the address is presented
    bit [7:0] mem_a [256];
    bit [7:0] mem_b [256];
    bit [7:0] pipe_a;
    bit [7:0] pipe_b [3];
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_din;
        if (b_we) mem_b[b_addr] <= b_din;
        pipe_a    <= mem_a[a_addr];
        pipe_b[0] <= mem_b[b_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_dout = pipe_a;
    assign b_dout = pipe_b[2];

    // Model state per lane: when the arbiter is next free, what was granted, what read returns when
    int       cyc, n_cmp, n_bad;
    int       m_last [2], m_free [2], e_gcyc [2], e_gwho [2], e_rvcyc [2], e_rvwho [2];
    bit       e_gwe [2];
    bit [7:0] e_addr [2], e_din [2], e_rvdat [2];
    bit [7:0] e_rd [2][2];
    bit [7:0] xm [2][256];
`ifdef MEMARB_LOCK_EN
    bit       m_locked [2];
`endif
    int       order_a [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int l);
        m_last[l] = 1;  m_free[l] = 0;
        e_gcyc[l] = -1; e_gwho[l] = 0; e_gwe[l] = 1'b0;
        e_rvcyc[l] = -1; e_rvwho[l] = 0; e_rvdat[l] = 8'h00;
        e_addr[l] = 8'h00; e_din[l] = 8'h00;
        e_rd[l][0] = 8'h00; e_rd[l][1] = 8'h00;
`ifdef MEMARB_LOCK_EN
        m_locked[l] = 1'b0;
`endif
    endtask

    // Applies the inputs sampled at the edge that ends cycle cyc
    task automatic model_edge(input int l);
        int n, w, lat;
        bit r0, r1;
        n   = cyc;
        lat = (l == 0) ? 1 : 3;
        if (rst) begin
            model_reset(l);
            return;
        end
        if (n == e_gcyc[l] && e_gwe[l]) xm[l][e_addr[l]] = e_din[l];
`ifdef MEMARB_LOCK_EN
        if (n == e_gcyc[l]) m_locked[l] = (e_gwho[l] == 1) ? lock1 : lock0;
`endif
        if (n < m_free[l]) return;
        r0 = req0;
        r1 = req1;
`ifdef MEMARB_LOCK_EN
        if (m_locked[l] && m_last[l] == 0 && r0) r1 = 1'b0;
        if (m_locked[l] && m_last[l] == 1 && r1) r0 = 1'b0;
        m_locked[l] = 1'b0;
`endif
        if (!r0 && !r1) return;
        w = (r0 && r1) ? 1 - m_last[l] : (r1 ? 1 : 0);
        m_last[l] = w;
        e_gcyc[l] = n + 1;
        e_gwho[l] = w;
        e_gwe[l]  = (w == 1) ? we1 : we0;
        e_addr[l] = (w == 1) ? addr1 : addr0;
        if (e_gwe[l]) begin
            e_din[l]  = (w == 1) ? wdata1 : wdata0;
            m_free[l] = n + 2;
        end else begin
            e_rvcyc[l] = n + 2 + lat;
            e_rvwho[l] = w;
            e_rvdat[l] = xm[l][e_addr[l]];
            m_free[l]  = n + 3 + lat;
        end
    endtask

    task automatic compare_lane(input int l);
        logic g0, g1, v0, v1, we;
        logic [7:0] ad, di, d0, d1;
        if (l == 0) begin
            g0 = a_gnt0; g1 = a_gnt1; v0 = a_rv0; v1 = a_rv1; we = a_we;
            ad = a_addr; di = a_din; d0 = a_rd0; d1 = a_rd1;
            if (g0) order_a.push_back(0);
            if (g1) order_a.push_back(1);
        end else begin
            g0 = b_gnt0; g1 = b_gnt1; v0 = b_rv0; v1 = b_rv1; we = b_we;
            ad = b_addr; di = b_din; d0 = b_rd0; d1 = b_rd1;
        end
        if (cyc == e_rvcyc[l]) e_rd[l][e_rvwho[l]] = e_rvdat[l];
        chk($sformatf("L%0d_gnt0", l), 32'(g0), 32'(cyc == e_gcyc[l] && e_gwho[l] == 0));
        chk($sformatf("L%0d_gnt1", l), 32'(g1), 32'(cyc == e_gcyc[l] && e_gwho[l] == 1));
        chk($sformatf("L%0d_memwr_en", l), 32'(we), 32'(cyc == e_gcyc[l] && e_gwe[l]));
        chk($sformatf("L%0d_memaddr", l), 32'(ad), 32'(e_addr[l]));
        chk($sformatf("L%0d_memdata_in", l), 32'(di), 32'(e_din[l]));
        chk($sformatf("L%0d_rvalid0", l), 32'(v0), 32'(cyc == e_rvcyc[l] && e_rvwho[l] == 0));
        chk($sformatf("L%0d_rvalid1", l), 32'(v1), 32'(cyc == e_rvcyc[l] && e_rvwho[l] == 1));
        chk($sformatf("L%0d_rdata0", l), 32'(d0), 32'(e_rd[l][0]));
        chk($sformatf("L%0d_rdata1", l), 32'(d1), 32'(e_rd[l][1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        @(negedge clk);
        compare_lane(0);
        compare_lane(1);
    endtask

    task automatic idle(input int k);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (k) tick();
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_lane(0);
        compare_lane(1);
        chk("rst_outputs_a", 32'(|{a_gnt0, a_gnt1, a_rv0, a_rv1, a_we, a_addr, a_din, a_rd0, a_rd1}), 32'd0);
        chk("rst_outputs_b", 32'(|{b_gnt0, b_gnt1, b_rv0, b_rv1, b_we, b_addr, b_din, b_rd0, b_rd1}), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (k) tick();
        rst = 1'b0;
    endtask

    // One requester of the random agent: a new command after a grant or when idle, rare abandonment
    task automatic rand_req(input int k, input logic granted);
        logic cur;
        cur = (k == 1) ? req1 : req0;
        if (!cur || granted) begin
            cur = ($urandom_range(0, 2) != 0);
            if (k == 1) begin
                we1 = 1'($urandom_range(0, 1));
                addr1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                wdata1 = 8'($urandom_range(0, 255));
            end else begin
                we0 = 1'($urandom_range(0, 1));
                addr0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                wdata0 = 8'($urandom_range(0, 255));
            end
        end else if ($urandom_range(0, 15) == 0) begin
            cur = 1'b0;
        end else begin
            cur = 1'b1;
        end
        if (k == 1) req1 = cur;
        else req0 = cur;
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
`ifdef MEMARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single write from requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
        tick();
        chk("wr_gnt0", 32'(a_gnt0), 32'd1);
        chk("wr_memwr_en", 32'(a_we), 32'd1);
        chk("wr_memaddr", 32'(a_addr), 32'h10);
        chk("wr_memdata_in", 32'(a_din), 32'hA5);
        req0 = 1'b0;
        tick();
        chk("wr_memwr_en_single", 32'(a_we), 32'd0);
        chk("wr_no_rvalid", 32'(a_rv0 | a_rv1), 32'd0);
        idle(2);

        // Requester 1 reads back the same location, RD_LAT 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        tick();
        chk("rd_gnt1", 32'(a_gnt1), 32'd1);
        req1 = 1'b0;
        tick();
        tick();
        chk("rd_rvalid1", 32'(a_rv1), 32'd1);
        chk("rd_rdata1", 32'(a_rd1), 32'hA5);
        chk("rd_rvalid0_quiet", 32'(a_rv0), 32'd0);
        idle(6);

        // Both requesters held high: strict alternation
        order_a.delete();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h22;
        repeat (10) tick();
        chk("alt_count", 32'(order_a.size() >= 4), 32'd1);
        if (order_a.size() >= 4) begin
            chk("alt_0", 32'(order_a[0]), 32'd0);
            chk("alt_1", 32'(order_a[1]), 32'd1);
            chk("alt_2", 32'(order_a[2]), 32'd0);
            chk("alt_3", 32'(order_a[3]), 32'd1);
        end
        idle(4);

        // RD_LAT 3 read of 0x3C after writing 0x5A there
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'h5A;
        tick();
        idle(3);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
        tick();
        req0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            chk($sformatf("lat3_memaddr_n%0d", k), 32'(b_addr), 32'h3C);
            chk($sformatf("lat3_no_rvalid_n%0d", k), 32'(b_rv0), 32'd0);
        end
        tick();
        chk("lat3_rvalid0", 32'(b_rv0), 32'd1);
        chk("lat3_rdata0", 32'(b_rd0), 32'h5A);
        idle(4);

        // Reset while a read is waiting for memory
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        tick();
        req0 = 1'b0;
        tick();
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_rvalid_a", 32'(a_rv0), 32'd0);
            chk("post_rst_no_rvalid_b", 32'(b_rv0), 32'd0);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        tick();
        chk("post_rst_first_gnt0", 32'(a_gnt0), 32'd1);
        chk("post_rst_first_gnt1", 32'(a_gnt1), 32'd0);
        idle(8);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic g0, g1;
            g0 = a_gnt0;
            g1 = a_gnt1;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(2);
            end else begin
                rand_req(0, g0);
                rand_req(1, g1);
`ifdef MEMARB_LOCK_EN
                lock0 = ($urandom_range(0, 3) == 0);
                lock1 = ($urandom_range(0, 3) == 0);
`endif
                tick();
            end
        end
        idle(10);

`ifdef MEMARB_LOCK_EN
        // Locked read-modify-write by requester 0 while requester 1 keeps asking
        lock0 = 1'b0; lock1 = 1'b0;
        do_reset(1);
        order_a.delete();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40; lock0 = 1'b1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h41; wdata1 = 8'h77;
        tick();
        tick();
        we0 = 1'b1; wdata0 = 8'h99; lock0 = 1'b0;
        for (int k = 0; k < 12 && order_a.size() < 2; k++) tick();
        req0 = 1'b0;
        for (int k = 0; k < 12 && order_a.size() < 3; k++) tick();
        req1 = 1'b0;
        chk("lock_count", 32'(order_a.size()), 32'd3);
        if (order_a.size() >= 3) begin
            chk("lock_0", 32'(order_a[0]), 32'd0);
            chk("lock_1", 32'(order_a[1]), 32'd0);
            chk("lock_2", 32'(order_a[2]), 32'd1);
        end
        idle(8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
